// File: rtl/top_dig_pkg.sv
// Shared widths, opcodes and PUF seed values for the top_dig test chip.
package top_dig_pkg;

  localparam int FRAME_W   = 136;
  localparam int PAYLOAD_W = 128;
  localparam int OP_W      = 8;

  localparam logic [7:0] FRAME_BITS = 8'(FRAME_W);

  localparam logic [OP_W-1:0] OP_EXC_DD = 8'h01;
  localparam logic [OP_W-1:0] OP_EXC_XR = 8'h02;
  localparam logic [OP_W-1:0] OP_RD_DD  = 8'h03;
  localparam logic [OP_W-1:0] OP_RD_XR  = 8'h04;
  localparam logic [OP_W-1:0] OP_CHAL   = 8'h05;
  localparam logic [OP_W-1:0] OP_SEED   = 8'h06;

  localparam logic [PAYLOAD_W-1:0] DD_SEED = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [PAYLOAD_W-1:0] XR_SEED = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;

  function automatic logic [PAYLOAD_W-1:0] rotl(input logic [PAYLOAD_W-1:0] v,
                                                input int unsigned sh);
    return (v << sh) | (v >> (PAYLOAD_W - sh));
  endfunction

endpackage

// File: rtl/top_dig_spi_frame_slave.sv
// SPI mode-0 slave: pin synchronisers, SSEL deglitch, edge detection, 136-bit
// receive/transmit shift registers and a saturating bit counter.
module spi_frame_slave
  import top_dig_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ssel,
  input  logic               sclk,
  input  logic               mosi,
  input  logic [FRAME_W-1:0] tx_frame,
  output logic               miso,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data
);

  logic [2:0]         ssel_s;
  logic               ssel_f;
  logic [2:0]         sclk_s;
  logic [1:0]         mosi_s;
  logic [FRAME_W-1:0] shift_in;
  logic [FRAME_W-1:0] shift_out;
  logic [7:0]         bit_cnt;

  logic ssel_fall;
  logic ssel_rise;
  logic sclk_rise;

  // SSEL changes state only after three agreeing samples, so any pulse shorter
  // than two CLK periods can never be accepted as a select edge.
  assign ssel_fall = ssel_f & (ssel_s == 3'b000);
  assign ssel_rise = ~ssel_f & (ssel_s == 3'b111);
  assign sclk_rise = sclk_s[1] & ~sclk_s[2] & ~ssel_f;

  assign frame_valid = ssel_rise & (bit_cnt == FRAME_BITS);
  assign frame_data  = shift_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_s    <= 3'b111;
      ssel_f    <= 1'b1;
      sclk_s    <= '0;
      mosi_s    <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      bit_cnt   <= '0;
      miso      <= 1'b0;
    end else begin
      ssel_s <= {ssel_s[1:0], ssel};
      sclk_s <= {sclk_s[1:0], sclk};
      mosi_s <= {mosi_s[0], mosi};

      if (ssel_fall) ssel_f <= 1'b0;
      else if (ssel_rise) ssel_f <= 1'b1;

      if (ssel_fall) begin
        bit_cnt   <= '0;
        shift_out <= tx_frame;
        miso      <= tx_frame[FRAME_W-1];
      end else if (sclk_rise) begin
        shift_in  <= {shift_in[FRAME_W-2:0], mosi_s[1]};
        shift_out <= {shift_out[FRAME_W-2:0], 1'b0};
        miso      <= shift_out[FRAME_W-2];
        if (bit_cnt != FRAME_BITS) bit_cnt <= bit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/top_dig.sv
// Test-chip top: SPI command frames drive the DD-PUF / XOR-PUF models.
// Build option: TOP_DIG_ECHO_EN makes unrecognised opcodes loop the frame back.
module top_dig
  import top_dig_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic SSEL,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  logic                 frame_valid;
  logic [FRAME_W-1:0]   frame_data;
  logic [FRAME_W-1:0]   received;
  logic [FRAME_W-1:0]   to_send;
  logic [PAYLOAD_W-1:0] challenge;
  logic [PAYLOAD_W-1:0] dd;
  logic [PAYLOAD_W-1:0] xr;
  logic [15:0]          dd_cnt;
  logic [15:0]          xr_cnt;

  logic [OP_W-1:0]      op;
  logic [PAYLOAD_W-1:0] pl;

  assign op = frame_data[FRAME_W-1:PAYLOAD_W];
  assign pl = frame_data[PAYLOAD_W-1:0];

  spi_frame_slave u_spi (
    .clk         (CLK),
    .rst_n       (RESET),
    .ssel        (SSEL),
    .sclk        (SCLK),
    .mosi        (MOSI),
    .tx_frame    (to_send),
    .miso        (MISO),
    .frame_valid (frame_valid),
    .frame_data  (frame_data)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      received  <= '0;
      to_send   <= '0;
      challenge <= '0;
      dd        <= DD_SEED;
      xr        <= XR_SEED;
      dd_cnt    <= '0;
      xr_cnt    <= '0;
    end else begin
      if (dd_cnt != 16'd0) begin
        dd     <= rotl(dd, 1) ^ challenge;
        dd_cnt <= dd_cnt - 16'd1;
      end
      if (xr_cnt != 16'd0) begin
        xr     <= rotl(xr, 3) ^ ~challenge;
        xr_cnt <= xr_cnt - 16'd1;
      end

      // Opcode effects are assigned last so they win over a running excitation.
      if (frame_valid) begin
        received <= frame_data;
        case (op)
          OP_EXC_DD: dd_cnt <= pl[15:0];
          OP_EXC_XR: xr_cnt <= pl[15:0];
          OP_RD_DD:  to_send <= {OP_RD_DD, dd};
          OP_RD_XR:  to_send <= {OP_RD_XR, xr};
          OP_CHAL: begin
            challenge <= pl;
            to_send   <= {OP_CHAL, pl};
          end
          OP_SEED: begin
            dd     <= pl;
            xr     <= pl;
            dd_cnt <= '0;
            xr_cnt <= '0;
          end
          default: begin
`ifdef TOP_DIG_ECHO_EN
            to_send <= frame_data;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_top_dig.sv
// Directed + randomised SPI frame bench for top_dig with a frame-level model.
`timescale 1ns/1ps
module tb_top_dig;

  logic clk;
  logic rst_n;
  logic ssel;
  logic sclk;
  logic mosi;
  logic miso;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] DD_SEED_C = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] XR_SEED_C = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;

  // Reference model state, updated once per accepted frame.
  logic [135:0] m_received;
  logic [135:0] m_to_send;
  logic [127:0] m_dd;
  logic [127:0] m_xr;
  logic [127:0] m_chal;

  top_dig dut (
    .CLK   (clk),
    .RESET (rst_n),
    .SSEL  (ssel),
    .SCLK  (sclk),
    .MOSI  (mosi),
    .MISO  (miso)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_received = '0;
    m_to_send  = '0;
    m_dd       = DD_SEED_C;
    m_xr       = XR_SEED_C;
    m_chal     = '0;
  endtask

  // Excitation rules applied n times; frames are long enough that each run
  // completes before the next opcode executes.
  function automatic logic [127:0] run_dd(input logic [127:0] v, input logic [127:0] c,
                                          input int n);
    for (int i = 0; i < n; i++) v = {v[126:0], v[127]} ^ c;
    return v;
  endfunction

  function automatic logic [127:0] run_xr(input logic [127:0] v, input logic [127:0] c,
                                          input int n);
    for (int i = 0; i < n; i++) v = {v[124:0], v[127:125]} ^ ~c;
    return v;
  endfunction

  task automatic model_exec(input logic [135:0] f);
    logic [7:0]   op;
    logic [127:0] pl;
    op = f[135:128];
    pl = f[127:0];
    m_received = f;
    case (op)
      8'h01: m_dd = run_dd(m_dd, m_chal, int'(pl[15:0]));
      8'h02: m_xr = run_xr(m_xr, m_chal, int'(pl[15:0]));
      8'h03: m_to_send = {8'h03, m_dd};
      8'h04: m_to_send = {8'h04, m_xr};
      8'h05: begin m_chal = pl; m_to_send = {8'h05, pl}; end
      8'h06: begin m_dd = pl; m_xr = pl; end
      default: begin
`ifdef TOP_DIG_ECHO_EN
        m_to_send = f;
`endif
      end
    endcase
  endtask

  // driver: sends tx[nbits-1:0] MSB first, optional 15 ns SSEL glitch after bit glitch_at
  task automatic spi_xfer(input logic [143:0] tx, input int nbits, input int glitch_at,
                          output logic [135:0] rx);
    rx = '0;
    @(posedge clk); #2;
    ssel = 1'b0;
    repeat (10) @(posedge clk); #2;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[nbits-1-i];
      repeat (5) @(posedge clk); #2;
      if (i < 136) rx[135-i] = miso;
      sclk = 1'b1;
      repeat (5) @(posedge clk); #2;
      sclk = 1'b0;
      if (i == glitch_at) begin
        ssel = 1'b1;
        #15;
        ssel = 1'b0;
      end
    end
    repeat (5) @(posedge clk); #2;
    ssel = 1'b1;
  endtask

  // Scoreboard for one frame: MISO stream, then RECEIVED/TO_SEND 4 CLK after SSEL rise.
  task automatic run_frame(input logic [143:0] tx, input int nbits, input int glitch_at,
                           output logic [135:0] rx);
    logic [135:0] mask;
    logic [135:0] exp_rx;
    int nb;
    nb     = (nbits > 136) ? 136 : nbits;
    mask   = '1;
    mask   = mask << (136 - nb);
    exp_rx = m_to_send;
    spi_xfer(tx, nbits, glitch_at, rx);
    repeat (4) @(posedge clk); #1;
    check("miso_stream", rx & mask, exp_rx & mask);
    if (nbits >= 136) model_exec(tx[135:0]);
    check("received", dut.received, m_received);
    check("to_send", dut.to_send, m_to_send);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [135:0] rx;
    logic [127:0] p;
    logic [7:0]   op;
    logic [127:0] pl;

    rst_n = 1'b0;
    ssel  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_miso", {135'd0, miso}, 136'd0);
    check("rst_received", dut.received, 136'd0);
    check("rst_to_send", dut.to_send, 136'd0);
    check("rst_dd", {8'h00, dut.dd}, {8'h00, DD_SEED_C});
    check("rst_xr", {8'h00, dut.xr}, {8'h00, XR_SEED_C});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // read DD seed
    run_frame({8'h00, 8'h03, 128'd0}, 136, -1, rx);
    run_frame({8'h00, 8'h00, 128'd0}, 136, -1, rx);
    check("rd_dd_seed", rx, {8'h03, DD_SEED_C});

    // random frame, then a plain read of TO_SEND
    run_frame({8'h00, 8'($urandom_range(7, 255)), rand128()}, 136, -1, rx);
    run_frame({8'h00, 8'hff, 128'd0}, 136, -1, rx);

    // seed 1, excite DD 10 cycles with zero challenge
    run_frame({8'h00, 8'h06, 128'd1}, 136, -1, rx);
    run_frame({8'h00, 8'h01, 128'd10}, 136, -1, rx);
    run_frame({8'h00, 8'h03, 128'd0}, 136, -1, rx);
    run_frame({8'h00, 8'h00, 128'd0}, 136, -1, rx);
    check("dd_rot10", rx, {8'h03, 128'h400});

    // challenge P, then XR from zero for one cycle gives ~P
    p = rand128();
    run_frame({8'h00, 8'h05, p}, 136, -1, rx);
    run_frame({8'h00, 8'h06, 128'd0}, 136, -1, rx);
    check("chal_echo", rx, {8'h05, p});
    run_frame({8'h00, 8'h02, 128'd1}, 136, -1, rx);
    run_frame({8'h00, 8'h04, 128'd0}, 136, -1, rx);
    run_frame({8'h00, 8'h00, 128'd0}, 136, -1, rx);
    check("xr_not_chal", rx, {8'h04, ~p});

    // aborted frame after 70 bits, then a good frame
    run_frame({8'h00, 8'h05, rand128()}, 70, -1, rx);
    run_frame({8'h00, 8'h03, 128'd0}, 136, -1, rx);

    // overlong frame: last 136 bits count
    run_frame({4'ha, 4'h0, 8'h05, rand128()}, 140, -1, rx);
    // SSEL glitch mid-frame must be ignored
    run_frame({8'h00, 8'h05, rand128()}, 136, 60, rx);

    // randomised opcode mix
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 6))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        4: op = 8'h05;
        5: op = 8'h06;
        default: op = 8'($urandom_range(7, 255));
      endcase
      pl = rand128();
      if (op == 8'h01 || op == 8'h02) pl[15:0] = 16'($urandom_range(0, 300));
      run_frame({8'h00, op, pl}, 136, -1, rx);
    end

    // reset in the middle of a 128-cycle DD excitation
    run_frame({8'h00, 8'h01, 128'd128}, 136, -1, rx);
    repeat (30) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dd", {8'h00, dut.dd}, {8'h00, DD_SEED_C});
    check("mid_rst_xr", {8'h00, dut.xr}, {8'h00, XR_SEED_C});
    check("mid_rst_cnt", {104'd0, dut.dd_cnt, dut.xr_cnt}, 136'd0);
    check("mid_rst_miso", {135'd0, miso}, 136'd0);
    check("mid_rst_regs", dut.received | dut.to_send, 136'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_frame({8'h00, 8'h03, 128'd0}, 136, -1, rx);
    run_frame({8'h00, 8'h00, 128'd0}, 136, -1, rx);
    check("post_rst_rd", rx, {8'h03, DD_SEED_C});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
